// File: rtl/aq_iu_ag_sched.sv
// ---------------------------------------------------------------------------
// AqIuAgSched -- scheduler in front of the shared address-generator adder.
//
// Two requesters compete for one adder.  req0 carries the BJU jump/branch
// target computation; req1 carries auipc / secondary address work.  A granted
// request is copied into an operand register and presented to the adder for
// exactly one cycle (CALC).  The adder sum is captured and offered on the
// result handshake (HOLD) until the consumer takes it.
//
// Optional feature macro: AQ_IU_AG_SCHED_RR_EN
//   undefined : fixed priority, req0 wins over req1 (no pointer state)
//   defined   : round-robin with a 1-bit pointer that favours the requester
//               not granted last; the pointer resets to favour req0
//
// Ports
//   forever_cpuclk           in   clock, all state changes on rising edge
//   cpurst                   in   synchronous active-high reset
//   req0_* / req1_*          in   valid, use_pc, pc[39:0], src0[63:0],
//                                 offset[63:0] per requester
//   req0_rdy / req1_rdy      out  grant; transfer when vld and rdy both high
//   sched_ag_use_pc          out  adder operand: select pc instead of src0
//   sched_ag_cur_pc[39:0]    out  adder operand: pc
//   sched_ag_src0[63:0]      out  adder operand: src0
//   sched_ag_offset[63:0]    out  adder operand: offset
//   sched_ag_offset_sel      out  adder: add the offset
//   sched_ag_gateclk_sel     out  adder: enable its clock gate this cycle
//   ag_sched_pc[63:0]        in   combinational adder sum for this cycle
//   res_vld / res_rdy        out/in result handshake
//   res_id                   out  0 = req0, 1 = req1
//   res_pc[63:0]             out  full 64-bit adder sum
//   iu_flush                 in   pipeline flush, kills any request in flight
// ---------------------------------------------------------------------------
module aq_iu_ag_sched (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        req0_vld,
  input  logic        req0_use_pc,
  input  logic [39:0] req0_pc,
  input  logic [63:0] req0_src0,
  input  logic [63:0] req0_offset,
  output logic        req0_rdy,
  input  logic        req1_vld,
  input  logic        req1_use_pc,
  input  logic [39:0] req1_pc,
  input  logic [63:0] req1_src0,
  input  logic [63:0] req1_offset,
  output logic        req1_rdy,
  output logic        sched_ag_use_pc,
  output logic [39:0] sched_ag_cur_pc,
  output logic [63:0] sched_ag_src0,
  output logic [63:0] sched_ag_offset,
  output logic        sched_ag_offset_sel,
  output logic        sched_ag_gateclk_sel,
  input  logic [63:0] ag_sched_pc,
  output logic        res_vld,
  output logic        res_id,
  output logic [63:0] res_pc,
  input  logic        res_rdy,
  input  logic        iu_flush
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } stateT;

  stateT       r_state;
  stateT       w_nextState;

  logic        r_opUsePc;
  logic [39:0] r_opPc;
  logic [63:0] r_opSrc0;
  logic [63:0] r_opOffset;
  logic        r_opId;

  logic [63:0] r_resPc;
  logic        r_resId;

  logic        w_grantWindow;
  logic        w_pick1;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_anyGrant;

`ifdef AQ_IU_AG_SCHED_RR_EN
  // r_rrPtr = 1 means req1 wins when both requesters are valid.
  logic        r_rrPtr;
`endif

  // A grant may only be issued when the adder slot is free: either nothing
  // is in flight (IDLE) or the held result is being consumed right now, which
  // allows back-to-back operation.  Reset and flush suppress every grant.
  always_comb begin
    w_grantWindow = 1'b0;
    if (!cpurst && !iu_flush) begin
      w_grantWindow = (r_state == IDLE) || ((r_state == HOLD) && res_rdy);
    end
  end

  // Arbitration.  w_pick1 says req1 is the chosen requester; otherwise req0
  // takes the slot when it is valid.
  always_comb begin
`ifdef AQ_IU_AG_SCHED_RR_EN
    w_pick1 = req1_vld && (!req0_vld || r_rrPtr);
`else
    w_pick1 = req1_vld && !req0_vld;
`endif
    w_grant0   = w_grantWindow && req0_vld && !w_pick1;
    w_grant1   = w_grantWindow && w_pick1;
    w_anyGrant = w_grant0 || w_grant1;
  end

  // State register.  Reset dominates everything else.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic.  Flush returns to IDLE from any state and wins over a
  // simultaneous result acceptance or grant.
  always_comb begin
    w_nextState = r_state;
    if (iu_flush) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyGrant) begin
            w_nextState = CALC;
          end
        end
        CALC: begin
          w_nextState = HOLD;
        end
        HOLD: begin
          if (res_rdy) begin
            w_nextState = w_anyGrant ? CALC : IDLE;
          end
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  // Output decode.  The adder sees operands only during CALC, and nothing at
  // all while reset is asserted, so it can stay clock-gated the rest of the
  // time.
  always_comb begin
    req0_rdy             = w_grant0;
    req1_rdy             = w_grant1;
    res_vld              = (r_state == HOLD);
    res_id               = r_resId;
    res_pc               = r_resPc;
    sched_ag_use_pc      = 1'b0;
    sched_ag_cur_pc      = 40'd0;
    sched_ag_src0        = 64'd0;
    sched_ag_offset      = 64'd0;
    sched_ag_offset_sel  = 1'b0;
    sched_ag_gateclk_sel = 1'b0;
    if ((r_state == CALC) && !cpurst) begin
      sched_ag_use_pc      = r_opUsePc;
      sched_ag_cur_pc      = r_opPc;
      sched_ag_src0        = r_opSrc0;
      sched_ag_offset      = r_opOffset;
      sched_ag_offset_sel  = 1'b1;
      sched_ag_gateclk_sel = 1'b1;
    end
  end

  // Operand register.  Loaded from the granted requester; a flush discards
  // whatever was captured so no stale operands survive into a later CALC.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst || iu_flush) begin
      r_opUsePc  <= 1'b0;
      r_opPc     <= 40'd0;
      r_opSrc0   <= 64'd0;
      r_opOffset <= 64'd0;
      r_opId     <= 1'b0;
    end else if (w_grant1) begin
      r_opUsePc  <= req1_use_pc;
      r_opPc     <= req1_pc;
      r_opSrc0   <= req1_src0;
      r_opOffset <= req1_offset;
      r_opId     <= 1'b1;
    end else if (w_grant0) begin
      r_opUsePc  <= req0_use_pc;
      r_opPc     <= req0_pc;
      r_opSrc0   <= req0_src0;
      r_opOffset <= req0_offset;
      r_opId     <= 1'b0;
    end
  end

  // Result register.  Captured only at the end of CALC, so res_pc and res_id
  // stay frozen for the whole of HOLD.  The adder sum is kept at full width.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_resPc <= 64'd0;
      r_resId <= 1'b0;
    end else if ((r_state == CALC) && !iu_flush) begin
      r_resPc <= ag_sched_pc;
      r_resId <= r_opId;
    end
  end

`ifdef AQ_IU_AG_SCHED_RR_EN
  // Round-robin pointer: after each grant, favour the other requester.
  // Grants never occur under flush, so only an actual grant moves it.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_rrPtr <= 1'b0;
    end else if (w_anyGrant) begin
      r_rrPtr <= w_grant0;
    end
  end
`endif

endmodule
